ws_output_deskew: RTL and testbench

//  Reader/collector for the bottom edge of the weight-stationary systolic array.

---
 rtl/ws_output_deskew.sv | 128 ++++++++++++
 tb/tb_ws_output_deskew.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws_output_deskew.sv
// ws_output_deskew
//   Collector for the bottom edge of the weight-stationary systolic array.
//   Column partial sums arrive skewed by one cycle per column. Each lane is
//   delayed so that all lanes of an output row line up. Complete rows go into
//   a FIFO that is read over a valid/ready stream. The block requests a stall
//   from the sequencer before the FIFO can overflow.
//
// Ports
//   clk, rst    clock; synchronous active-high reset
//   shift_en    array advance enable; every delay stage moves only when high
//   c_valid     column 0 of c_in starts a new output row
//   c_in        bottom-row PE outputs, lane j = [j*ACC_WIDTH +: ACC_WIDTH]
//   row_valid   row_data holds an aligned row
//   row_ready   consumer accepts the row when row_valid & row_ready
//   row_data    aligned row in the same lane order as c_in; zero when idle
//   fill_level  rows currently stored in the FIFO
//   stall_req   registered: free FIFO slots < N_COLS
//   overflow    sticky: a completed row was dropped because the FIFO was full
module ws_output_deskew #(
   parameter int N_COLS     = 4,
   parameter int ACC_WIDTH  = 32,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               shift_en,
   input  logic                               c_valid,
   input  logic [N_COLS*ACC_WIDTH-1:0]        c_in,
   output logic                               row_valid,
   input  logic                               row_ready,
   output logic [N_COLS*ACC_WIDTH-1:0]        row_data,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fill_level,
   output logic                               stall_req,
   output logic                               overflow
);

   localparam int RW = N_COLS * ACC_WIDTH;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   // ---------------------------------------------------------------- deskew
   logic [N_COLS-2:0] vld_sr;
   logic [RW-1:0]     aligned;
   logic              push;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_sr <= '0;
      end else if (shift_en) begin
         vld_sr[0] <= c_valid;
         for (int unsigned k = 1; k < N_COLS - 1; k++) begin
            vld_sr[k] <= vld_sr[k-1];
         end
      end
   end

   // Lane j needs N_COLS-1-j stages; the last lane is used straight from c_in.
   for (genvar j = 0; j < N_COLS - 1; j++) begin : g_lane
      localparam int DEPTH = N_COLS - 1 - j;
      logic [ACC_WIDTH-1:0] sr [DEPTH];

      always_ff @(posedge clk) begin
         if (shift_en) begin
            sr[0] <= c_in[j*ACC_WIDTH +: ACC_WIDTH];
            for (int unsigned k = 1; k < DEPTH; k++) begin
               sr[k] <= sr[k-1];
            end
         end
      end

      assign aligned[j*ACC_WIDTH +: ACC_WIDTH] = sr[DEPTH-1];
   end

   assign aligned[(N_COLS-1)*ACC_WIDTH +: ACC_WIDTH] = c_in[(N_COLS-1)*ACC_WIDTH +: ACC_WIDTH];

   // Delayed valid only counts on an advancing cycle, the same cycle the
   // last lane is sampled.
   assign push = shift_en & vld_sr[N_COLS-2];

   // ------------------------------------------------------------------ FIFO
   logic [RW-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          full, pop, accept;

   assign full   = (count == CW'(FIFO_DEPTH));
   assign pop    = row_valid & row_ready;
   // A pop in the same cycle frees the slot, so a push into a full FIFO is
   // still accepted then.
   assign accept = push & (~full | pop);

   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wr_ptr] <= aligned;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         stall_req <= 1'b0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({accept, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (push & full & ~pop) begin
            overflow <= 1'b1;
         end
         stall_req <= (FIFO_DEPTH - int'(count)) < N_COLS;
      end
   end

   assign row_valid  = (count != '0);
   assign row_data   = row_valid ? mem[rd_ptr] : '0;
   assign fill_level = count;

endmodule

// File: tb/tb_ws_output_deskew.sv
module tb_ws_output_deskew;

   localparam int N  = 4;
   localparam int W  = 32;
   localparam int D  = 8;
   localparam int DW = N * W;
   localparam int CW = $clog2(D + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          shift_en;
   logic          c_valid;
   logic [DW-1:0] c_in;
   logic          row_valid;
   logic          row_ready;
   logic [DW-1:0] row_data;
   logic [CW-1:0] fill_level;
   logic          stall_req;
   logic          overflow;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   ws_output_deskew #(.N_COLS(N), .ACC_WIDTH(W), .FIFO_DEPTH(D)) dut (
      .clk(clk), .rst(rst), .shift_en(shift_en), .c_valid(c_valid), .c_in(c_in),
      .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
      .fill_level(fill_level), .stall_req(stall_req), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------- reference model
   // Row-level view: a capture record collects one lane per advancing cycle,
   // complete rows go into a queue standing in for the FIFO.
   logic [DW-1:0] m_fifo[$];
   logic [DW-1:0] m_cap[$];
   int            m_capn[$];
   logic          m_stall = 1'b0;
   logic          m_ovf   = 1'b0;

   task automatic model_step(input logic r, se, cv, rdy, input logic [DW-1:0] cin);
      logic          pop, have, full, nstall;
      logic [DW-1:0] tmp, done;
      int            n;
      if (r) begin
         m_fifo.delete(); m_cap.delete(); m_capn.delete();
         m_stall = 1'b0; m_ovf = 1'b0;
         return;
      end
      pop  = (m_fifo.size() != 0) && rdy;
      have = 1'b0;
      done = '0;
      if (se) begin
         for (int i = 0; i < m_cap.size(); i++) begin
            tmp = m_cap[i];
            n   = m_capn[i];
            tmp[n*W +: W] = cin[n*W +: W];
            m_cap[i]  = tmp;
            m_capn[i] = n + 1;
         end
         if (m_cap.size() > 0 && m_capn[0] == N) begin
            done = m_cap.pop_front();
            void'(m_capn.pop_front());
            have = 1'b1;
         end
         if (cv) begin
            tmp = '0;
            tmp[W-1:0] = cin[W-1:0];
            m_cap.push_back(tmp);
            m_capn.push_back(1);
         end
      end
      nstall = (D - m_fifo.size()) < N;
      full   = (m_fifo.size() == D);
      if (pop) void'(m_fifo.pop_front());
      if (have) begin
         if (full && !pop) m_ovf = 1'b1;
         else m_fifo.push_back(done);
      end
      m_stall = nstall;
   endtask

   task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   task automatic check_model();
      check("valid", DW'(row_valid), DW'(m_fifo.size() != 0));
      check("data", row_data, (m_fifo.size() != 0) ? m_fifo[0] : '0);
      check("fill", DW'(fill_level), DW'(m_fifo.size()));
      check("stall", DW'(stall_req), DW'(m_stall));
      check("overflow", DW'(overflow), DW'(m_ovf));
   endtask

   // One clock: drive inputs, advance the model, sample #1 after the edge.
   task automatic step(input logic r, se, cv, rdy, input logic [DW-1:0] cin);
      rst = r; shift_en = se; c_valid = cv; row_ready = rdy; c_in = cin;
      model_step(r, se, cv, rdy, cin);
      @(posedge clk);
      #1;
      cyc++;
      check_model();
   endtask

   function automatic logic [DW-1:0] mk(input logic [W-1:0] l0, l1, l2, l3);
      return {l3, l2, l1, l0};
   endfunction

   function automatic logic [W-1:0] lv(input int tag, input int r, input int j);
      return W'(tag * 65536 + r * 256 + j);
   endfunction

   function automatic logic [DW-1:0] rnd_row();
      logic [DW-1:0] v;
      for (int j = 0; j < N; j++) v[j*W +: W] = $urandom;
      return v;
   endfunction

   function automatic logic [DW-1:0] tag_row(input int tag, input int r);
      return mk(lv(tag, r, 0), lv(tag, r, 1), lv(tag, r, 2), lv(tag, r, 3));
   endfunction

   // Feed nrows back-to-back rows with the column skew, shift_en held high.
   task automatic feed(input int tag, input int nrows, input int cycles,
                       input logic rdy, input logic rdy_last);
      logic [DW-1:0] cin;
      for (int k = 0; k < cycles; k++) begin
         cin = rnd_row();
         for (int j = 0; j < N; j++)
            if (k - j >= 0 && k - j < nrows) cin[j*W +: W] = lv(tag, k - j, j);
         step(1'b0, 1'b1, k < nrows, (k == cycles - 1) ? rdy_last : rdy, cin);
      end
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 1'b0, 1'b0, '0);
   endtask

   typedef struct {
      logic          se, cv, rdy;
      logic [DW-1:0] cin;
      logic          exp_valid;
      logic [DW-1:0] exp_data;
      int            exp_fill;
   } tv_t;

   tv_t           tbl[$];
   logic [W-1:0]  rv [3][4];
   logic [DW-1:0] cin;
   logic          se, cv;

   initial begin
      rst = 1'b1; shift_en = 1'b0; c_valid = 1'b0; row_ready = 1'b0; c_in = '0;

      // Single row: lane j = 100+j sampled at t0+j, other lanes carry junk.
      tbl.push_back('{1, 1, 1, mk(100, 900, 901, 902), 0, '0, 0});
      tbl.push_back('{1, 0, 1, mk(910, 101, 911, 912), 0, '0, 0});
      tbl.push_back('{1, 0, 1, mk(920, 921, 102, 922), 0, '0, 0});
      tbl.push_back('{1, 0, 1, mk(930, 931, 932, 103), 1, mk(100, 101, 102, 103), 1});
      tbl.push_back('{1, 0, 1, mk(0, 0, 0, 0), 0, '0, 0});

      // Three consecutive signed rows.
      rv[0] = '{32'hFFFF_FFFB, 32'd7, 32'h8000_0000, 32'h7FFF_FFFF};
      rv[1] = '{32'd0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FF9C};
      rv[2] = '{32'd123456, 32'hFFFE_1DC0, 32'h5555_5555, 32'hAAAA_AAAA};
      for (int k = 0; k < 7; k++) begin
         cin = '0;
         for (int j = 0; j < N; j++)
            cin[j*W +: W] = (k - j >= 0 && k - j < 3) ? rv[k-j][j] : W'(32'hBAD0_0000 + k * 16 + j);
         if (k >= 3 && k <= 5)
            tbl.push_back('{1, k < 3, 1, cin, 1, mk(rv[k-3][0], rv[k-3][1], rv[k-3][2], rv[k-3][3]), 1});
         else
            tbl.push_back('{1, k < 3, 1, cin, 0, '0, 0});
      end

      // Reset state
      do_reset();
      do_reset();
      check("rst_valid", DW'(row_valid), '0);
      check("rst_data", row_data, '0);
      check("rst_fill", DW'(fill_level), '0);
      check("rst_stall", DW'(stall_req), '0);
      check("rst_ovf", DW'(overflow), '0);

      // Table-driven single row and signed row sequence
      foreach (tbl[i]) begin
         step(1'b0, tbl[i].se, tbl[i].cv, tbl[i].rdy, tbl[i].cin);
         check($sformatf("tbl%0d_valid", i), DW'(row_valid), DW'(tbl[i].exp_valid));
         check($sformatf("tbl%0d_data", i), row_data, tbl[i].exp_data);
         check($sformatf("tbl%0d_fill", i), DW'(fill_level), DW'(tbl[i].exp_fill));
      end

      // Overflow: nine rows with no consumer, stall_req ignored
      do_reset();
      feed(3, 9, 12, 1'b0, 1'b0);
      check("ovf_fill", DW'(fill_level), DW'(D));
      check("ovf_flag", DW'(overflow), DW'(1));
      check("ovf_stall", DW'(stall_req), DW'(1));
      for (int r = 0; r < 8; r++) begin
         check($sformatf("ovf_drain%0d", r), row_data, tag_row(3, r));
         step(1'b0, 1'b0, 1'b0, 1'b1, rnd_row());
      end
      check("ovf_empty", DW'(row_valid), '0);
      check("ovf_sticky", DW'(overflow), DW'(1));

      // shift_en gap between lane-1 and lane-2 samples
      do_reset();
      cin = rnd_row(); cin[0*W +: W] = 200; step(1'b0, 1'b1, 1'b1, 1'b1, cin);
      cin = rnd_row(); cin[1*W +: W] = 201; step(1'b0, 1'b1, 1'b0, 1'b1, cin);
      step(1'b0, 1'b0, 1'b1, 1'b1, rnd_row());
      step(1'b0, 1'b0, 1'b0, 1'b1, rnd_row());
      cin = rnd_row(); cin[2*W +: W] = 202; step(1'b0, 1'b1, 1'b0, 1'b1, cin);
      check("gap_not_yet", DW'(row_valid), '0);
      cin = rnd_row(); cin[3*W +: W] = 203; step(1'b0, 1'b1, 1'b0, 1'b1, cin);
      check("gap_valid", DW'(row_valid), DW'(1));
      check("gap_data", row_data, mk(200, 201, 202, 203));
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 1'b1, 1'b0, 1'b1, rnd_row());
         check($sformatf("gap_noghost%0d", k), DW'(row_valid), '0);
      end

      // Full FIFO with simultaneous push and pop
      do_reset();
      feed(5, 9, 12, 1'b0, 1'b1);
      check("pp_fill", DW'(fill_level), DW'(D));
      check("pp_ovf", DW'(overflow), '0);
      for (int r = 1; r <= 8; r++) begin
         check($sformatf("pp_drain%0d", r), row_data, tag_row(5, r));
         step(1'b0, 1'b0, 1'b0, 1'b1, rnd_row());
      end

      // Reset with rows in the delay line and in the FIFO
      do_reset();
      feed(6, 5, 6, 1'b0, 1'b0);
      check("mid_fill", DW'(fill_level), DW'(3));
      step(1'b1, 1'b1, 1'b0, 1'b0, rnd_row());
      check("mid_rst_valid", DW'(row_valid), '0);
      check("mid_rst_fill", DW'(fill_level), '0);
      check("mid_rst_ovf", DW'(overflow), '0);
      check("mid_rst_stall", DW'(stall_req), '0);
      for (int k = 0; k < 6; k++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, rnd_row());
         check($sformatf("mid_noghost%0d", k), DW'(fill_level), '0);
      end

      // Random traffic, sequencer honouring stall_req
      do_reset();
      for (int k = 0; k < 1500; k++) begin
         se = ($urandom_range(0, 3) != 0) && !stall_req;
         cv = se && $urandom_range(0, 1);
         step(1'b0, se, cv, $urandom_range(0, 9) < 4, rnd_row());
      end
      check("rand_honour_ovf", DW'(overflow), '0);

      // Random traffic ignoring stall_req, with occasional resets
      do_reset();
      for (int k = 0; k < 1500; k++) begin
         step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 1), $urandom_range(0, 9) < 4, rnd_row());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
